// File: rtl/psum_output_buffer.sv
`default_nettype none
// ============================================================================
// psum_output_buffer : per-entry partial-sum store with valid/ready drain
// Rev 1.0
// ============================================================================
`ifndef OUTPUT_BUF_SIZE
`define OUTPUT_BUF_SIZE 32
`endif

module psum_output_buffer #(
    parameter int OUT_NUM = 16,
    parameter int ACC_W   = `OUTPUT_BUF_SIZE,
    localparam int IDX_W  = $clog2(OUT_NUM)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             acc_val_i,
    input  logic [ACC_W-1:0] acc_dat_i,
    input  logic             acc_last_i,
    output logic [ACC_W-1:0] acc_dat_o,
    output logic             acc_rdy_o,
    output logic [IDX_W-1:0] wr_idx_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_data_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             out_last_o,
    output logic             err_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_NUM - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] psum_q [OUT_NUM];
    logic [ACC_W-1:0] psum_d [OUT_NUM];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_ACCUM;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < OUT_NUM; i++) begin
                psum_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
            psum_q   <= psum_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        psum_d   = psum_q;

        if (clear_i) begin
            state_d  = ST_ACCUM;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            err_d    = 1'b0;
            for (int i = 0; i < OUT_NUM; i++) begin
                psum_d[i] = '0;
            end
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (acc_val_i) begin
                        psum_d[wr_ptr_q] = acc_dat_i;
                        if (acc_last_i) begin
                            if (wr_ptr_q == LAST_IDX) begin
                                state_d  = ST_DRAIN;
                                wr_ptr_d = '0;
                                rd_ptr_d = '0;
                            end else begin
                                wr_ptr_d = wr_ptr_q + 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    // Results arriving while draining are discarded and flagged.
                    if (acc_val_i) begin
                        err_d = 1'b1;
                    end
                    if (out_ready_i) begin
                        psum_d[rd_ptr_q] = '0;
                        if (rd_ptr_q == LAST_IDX) begin
                            state_d  = ST_ACCUM;
                            rd_ptr_d = '0;
                        end else begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    always_comb begin
        acc_rdy_o   = (state_q == ST_ACCUM);
        acc_dat_o   = (state_q == ST_ACCUM) ? psum_q[wr_ptr_q] : '0;
        wr_idx_o    = wr_ptr_q;
        out_valid_o = (state_q == ST_DRAIN);
        out_data_o  = psum_q[rd_ptr_q];
        out_idx_o   = rd_ptr_q;
        out_last_o  = (state_q == ST_DRAIN) && (rd_ptr_q == LAST_IDX);
        err_o       = err_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_psum_output_buffer.sv
`default_nettype none
// ============================================================================
// tb_psum_output_buffer : directed/random bench against a tile-level model
// Rev 1.0
// ============================================================================
module tb_psum_output_buffer;

    localparam int N = 16;
    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          acc_val_i = 1'b0;
    logic [W-1:0]  acc_dat_i = '0;
    logic          acc_last_i = 1'b0;
    logic [W-1:0]  acc_dat_o;
    logic          acc_rdy_o;
    logic [3:0]    wr_idx_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [W-1:0]  out_data_o;
    logic [3:0]    out_idx_o;
    logic          out_last_o;
    logic          err_o;

    psum_output_buffer #(.OUT_NUM(N), .ACC_W(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .acc_val_i(acc_val_i), .acc_dat_i(acc_dat_i), .acc_last_i(acc_last_i),
        .acc_dat_o(acc_dat_o), .acc_rdy_o(acc_rdy_o), .wr_idx_o(wr_idx_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_idx_o(out_idx_o), .out_last_o(out_last_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Tile-level model: value last written per entry, current entry, error flag.
    logic [W-1:0] m_tile [N];
    int           m_wr;
    bit           m_err;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_tile[i] = '0;
        m_wr  = 0;
        m_err = 0;
    endtask

    task automatic send(input logic [W-1:0] d, input bit last);
        check("accum_rdy", W'(acc_rdy_o), 1);
        check("accum_valid_low", W'(out_valid_o), 0);
        check("accum_dat", acc_dat_o, m_tile[m_wr]);
        check("accum_wr_idx", W'(wr_idx_o), W'(m_wr));
        acc_val_i  = 1'b1;
        acc_dat_i  = d;
        acc_last_i = last;
        tick();
        acc_val_i  = 1'b0;
        acc_last_i = 1'b0;
        m_tile[m_wr] = d;
        if (last) m_wr++;
    endtask

    task automatic random_tile();
        for (int e = 0; e < N; e++) begin
            int extra = $urandom_range(0, 2);
            for (int k = 0; k < extra; k++) send($urandom, 1'b0);
            send($urandom, 1'b1);
        end
    endtask

    task automatic drain(input bit bp, input bit inj);
        int  n = 0;
        int  cyc = 0;
        bit  rdy;
        while (n < N && cyc < 400) begin
            check("drain_valid", W'(out_valid_o), 1);
            check("drain_idx", W'(out_idx_o), W'(n));
            check("drain_data", out_data_o, m_tile[n]);
            check("drain_last", W'(out_last_o), W'(n == N - 1));
            check("drain_rdy_low", W'(acc_rdy_o), 0);
            check("drain_accdat_zero", acc_dat_o, 0);
            check("drain_err", W'(err_o), W'(m_err));
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready_i = rdy;
            if (inj && (cyc == 0 || $urandom_range(0, 3) == 0)) begin
                acc_val_i  = 1'b1;
                acc_last_i = 1'($urandom_range(0, 1));
                acc_dat_i  = 32'hFF;
                m_err = 1;
            end
            tick();
            acc_val_i  = 1'b0;
            acc_last_i = 1'b0;
            if (rdy) n++;
            cyc++;
        end
        check("drain_beats", W'(n), W'(N));
        out_ready_i = 1'b0;
        for (int i = 0; i < N; i++) m_tile[i] = '0;
        m_wr = 0;
        check("post_drain_valid", W'(out_valid_o), 0);
        check("post_drain_rdy", W'(acc_rdy_o), 1);
        check("post_drain_err", W'(err_o), W'(m_err));
    endtask

    initial begin
        model_clear();

        // Reset state
        rst_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b1;
        tick();
        check("rst_valid", W'(out_valid_o), 0);
        check("rst_rdy", W'(acc_rdy_o), 1);
        check("rst_accdat", acc_dat_o, 0);
        check("rst_err", W'(err_o), 0);
        check("rst_wr_idx", W'(wr_idx_o), 0);

        // Entry 0: 0x5 then 0xC with last
        send(32'h5, 1'b0);
        check("t2_accdat_5", acc_dat_o, 32'h5);
        send(32'hC, 1'b1);
        check("t2_wr_idx_1", W'(wr_idx_o), 1);
        for (int e = 1; e < N; e++) begin
            int extra = $urandom_range(0, 2);
            for (int k = 0; k < extra; k++) send($urandom, 1'b0);
            send($urandom, 1'b1);
        end
        check("t2_model_idx0", m_tile[0], 32'hC);
        drain(1'b1, 1'b0);

        // Full tile of i*3, back-to-back lasts, with a dropped result in drain
        for (int i = 0; i < N; i++) send(W'(i * 3), 1'b1);
        check("t3_valid_next", W'(out_valid_o), 1);
        drain(1'b0, 1'b1);
        check("t5_err_sticky", W'(err_o), 1);
        tick();
        check("t5_err_still", W'(err_o), 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        model_clear();
        check("t5_err_cleared", W'(err_o), 0);

        // clear_i against the final last of a tile
        for (int i = 0; i < N - 1; i++) send($urandom, 1'b1);
        check("t6_wr_idx_15", W'(wr_idx_o), 15);
        clear_i    = 1'b1;
        acc_val_i  = 1'b1;
        acc_last_i = 1'b1;
        acc_dat_i  = $urandom;
        tick();
        clear_i    = 1'b0;
        acc_val_i  = 1'b0;
        acc_last_i = 1'b0;
        model_clear();
        check("t6_no_drain", W'(out_valid_o), 0);
        check("t6_wr_idx", W'(wr_idx_o), 0);
        check("t6_rdy", W'(acc_rdy_o), 1);
        check("t6_accdat", acc_dat_o, 0);
        tick();
        check("t6_still_no_drain", W'(out_valid_o), 0);
        random_tile();
        drain(1'b1, 1'b0);

        // Reset in the middle of a drain
        random_tile();
        out_ready_i = 1'b1;
        repeat (5) tick();
        out_ready_i = 1'b0;
        check("t1_draining", W'(out_valid_o), 1);
        #2 rst_i = 1'b0;
        tick();
        check("t1_valid", W'(out_valid_o), 0);
        check("t1_rdy", W'(acc_rdy_o), 1);
        check("t1_accdat", acc_dat_o, 0);
        check("t1_err", W'(err_o), 0);
        check("t1_wr_idx", W'(wr_idx_o), 0);
        rst_i = 1'b1;
        model_clear();
        tick();
        random_tile();
        drain(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
